cfu_mac_initiator: RTL and testbench

Initiator side of the CFU command/response handshake. It streams operand word pairs from a local operand buffer into a SIMD MAC CFU and collects the accumulated result. Sequence per job: one accumulator-clear command, then LEN MAC commands (function_id 0). The last response is returned as the dot-product result. It sits between the operand buffer/DMA and the CFU, replacing CPU-issued custom instructions for long inner loops.

---
 rtl/cfu_init_pkg.sv | 25 ++
 rtl/cfu_rsp_watchdog.sv | 38 +++
 rtl/cfu_mac_initiator.sv | 171 +++++++++++++++++
 tb/tb_cfu_mac_initiator.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_init_pkg.sv
// Shared types and constants for the CFU MAC initiator.
// Optional response watchdog is enabled with CFU_INIT_TIMEOUT_EN.
package cfu_init_pkg;

    localparam int CFU_DATA_W = 32;
    localparam int CFU_FUNC_W = 10;

    localparam logic [CFU_FUNC_W-1:0] FUNC_MAC   = 10'h000;
    localparam logic [CFU_FUNC_W-1:0] FUNC_CLEAR = 10'h008;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR_CMD,
        ST_CLR_RSP,
        ST_FETCH,
        ST_MAC_CMD,
        ST_MAC_RSP,
        ST_FIN
    } state_e;

    function automatic logic is_rsp_state(input state_e s);
        return (s == ST_CLR_RSP) || (s == ST_MAC_RSP);
    endfunction

endpackage

// File: rtl/cfu_rsp_watchdog.sv
// Response watchdog: counts cycles spent waiting for a CFU response.
// Used by cfu_mac_initiator only when CFU_INIT_TIMEOUT_EN is defined.
module cfu_rsp_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Fires in the TIMEOUT-th consecutive waiting cycle.
    assign expire = count && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cfu_mac_initiator.sv
// Streams operand pairs into a SIMD MAC CFU: one clear, then LEN MACs.
// Define CFU_INIT_TIMEOUT_EN to add the response watchdog and err flag.
module cfu_mac_initiator
    import cfu_init_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic [CFU_DATA_W-1:0] result,
    output logic                  err,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [CFU_DATA_W-1:0] op_a,
    input  logic [CFU_DATA_W-1:0] op_b,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [CFU_FUNC_W-1:0] cmd_payload_function_id,
    output logic [CFU_DATA_W-1:0] cmd_payload_inputs_0,
    output logic [CFU_DATA_W-1:0] cmd_payload_inputs_1,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [CFU_DATA_W-1:0] rsp_payload_outputs_0
);

    state_e                state_q;
    state_e                state_d;
    logic [LEN_W-1:0]      remain_q;
    logic [LEN_W-1:0]      remain_d;
    logic [CFU_DATA_W-1:0] in0_q;
    logic [CFU_DATA_W-1:0] in0_d;
    logic [CFU_DATA_W-1:0] in1_q;
    logic [CFU_DATA_W-1:0] in1_d;
    logic [CFU_DATA_W-1:0] result_q;
    logic [CFU_DATA_W-1:0] result_d;
    logic                  in_rsp;
    logic                  rsp_expire;

    assign in_rsp = is_rsp_state(state_q);

`ifdef CFU_INIT_TIMEOUT_EN
    logic err_q;
    logic err_d;

    // Every RSP entry follows a non-RSP cycle, so that cycle reloads.
    cfu_rsp_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst_n  (reset),
        .load   (!in_rsp),
        .count  (in_rsp),
        .expire (rsp_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign rsp_expire = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        in0_d    = in0_q;
        in1_d    = in1_q;
        result_d = result_q;
`ifdef CFU_INIT_TIMEOUT_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remain_d = len;
                    in0_d    = '0;
                    in1_d    = '0;
`ifdef CFU_INIT_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = ST_CLR_CMD;
                end
            end
            ST_CLR_CMD: begin
                if (cmd_ready) state_d = ST_CLR_RSP;
            end
            ST_CLR_RSP: begin
                if (rsp_valid) begin
                    state_d = (remain_q == '0) ? ST_FIN : ST_FETCH;
                end else if (rsp_expire) begin
`ifdef CFU_INIT_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = ST_FIN;
                end
            end
            ST_FETCH: begin
                if (op_valid) begin
                    in0_d   = op_a;
                    in1_d   = op_b;
                    state_d = ST_MAC_CMD;
                end
            end
            ST_MAC_CMD: begin
                if (cmd_ready) begin
                    remain_d = remain_q - 1'b1;
                    state_d  = ST_MAC_RSP;
                end
            end
            ST_MAC_RSP: begin
                if (rsp_valid) begin
                    result_d = rsp_payload_outputs_0;
                    state_d  = (remain_q == '0) ? ST_FIN : ST_FETCH;
                end else if (rsp_expire) begin
`ifdef CFU_INIT_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            in0_q    <= '0;
            in1_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs decode straight from state, so reset drops them at once.
    assign cmd_valid = (state_q == ST_CLR_CMD) || (state_q == ST_MAC_CMD);
    assign rsp_ready = in_rsp;
    assign op_ready  = (state_q == ST_FETCH);
    assign done      = (state_q == ST_FIN);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign result    = result_q;

    assign cmd_payload_function_id =
        (state_q == ST_CLR_CMD) ? FUNC_CLEAR : FUNC_MAC;
    assign cmd_payload_inputs_0 = in0_q;
    assign cmd_payload_inputs_1 = in1_q;

endmodule

// File: tb/tb_cfu_mac_initiator.sv
// Directed bench for cfu_mac_initiator with a behavioural SIMD MAC CFU.
// Timeout checks compile in when CFU_INIT_TIMEOUT_EN is defined.
module tb_cfu_mac_initiator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    int errors = 0;
    int checks = 0;

    logic mac_stall = 1'b0;
    logic mute_mac  = 1'b0;
    logic mute_all  = 1'b0;

    int nclr = 0;
    int nmac = 0;

    logic [31:0] acc;
    logic [31:0] pa[$];
    logic [31:0] pb[$];
    logic [31:0] exp_q[$];

    cfu_mac_initiator #(
        .LEN_W   (16),
        .TIMEOUT (16)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .len                     (len),
        .busy                    (busy),
        .done                    (done),
        .result                  (result),
        .err                     (err),
        .op_valid                (op_valid),
        .op_ready                (op_ready),
        .op_a                    (op_a),
        .op_b                    (op_b),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cmd_ready = !(mac_stall && cmd_payload_function_id == 10'h000);

    function automatic logic [31:0] mac4(input logic [31:0] a_in,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        int s;
        logic [7:0] la;
        logic [7:0] lb;
        s = int'(a_in);
        for (int i = 0; i < 4; i++) begin
            la = a[8*i +: 8];
            lb = b[8*i +: 8];
            s += (int'($signed(la)) + 128) * int'($signed(lb));
        end
        return s;
    endfunction

    // Behavioural CFU: answers one cycle after accepting a command.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= '0;
            acc                   <= '0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                logic [31:0] nxt;
                if (cmd_payload_function_id == 10'h008) nxt = '0;
                else nxt = mac4(acc, cmd_payload_inputs_0, cmd_payload_inputs_1);
                acc <= nxt;
                if (!(mute_all || (mute_mac && cmd_payload_function_id == 10'h000))) begin
                    rsp_valid             <= 1'b1;
                    rsp_payload_outputs_0 <= nxt;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset && cmd_valid && cmd_ready) begin
            if (cmd_payload_function_id == 10'h008) nclr <= nclr + 1;
            else if (cmd_payload_function_id == 10'h000) nmac <= nmac + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [15:0] n, input int exp_lat,
                           input int exp_mac, input string tag);
        int cyc;
        int c0;
        int m0;
        logic hs;
        logic [31:0] er;
        c0 = nclr;
        m0 = nmac;
        @(negedge clk);
        start = 1'b1;
        len   = n;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 400) begin
            if (pa.size() != 0) begin
                op_valid = 1'b1;
                op_a     = pa[0];
                op_b     = pb[0];
            end else begin
                op_valid = 1'b0;
            end
            hs = op_valid && op_ready;
            @(negedge clk);
            cyc++;
            if (hs) begin
                void'(pa.pop_front());
                void'(pb.pop_front());
            end
        end
        op_valid = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        er = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        chk({tag, "_result"}, result, er);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_nclr"}, nclr - c0, 32'd1);
        chk({tag, "_nmac"}, nmac - m0, exp_mac);
    endtask

    initial begin
        int cyc;
        int m0;
        reset    = 1'b0;
        start    = 1'b0;
        len      = '0;
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_fid", {22'd0, cmd_payload_function_id}, 32'd0);
        chk("rst_in0", cmd_payload_inputs_0, 32'd0);
        chk("rst_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        pa.push_back(32'h01010101); pb.push_back(32'h01010101);
        exp_q.push_back(32'h00000204);
        run_job(16'd1, 6, 1, "j1");

        pa.push_back(32'h01010101); pb.push_back(32'h01010101);
        pa.push_back(32'h80808080); pb.push_back(32'h7F7F7F7F);
        exp_q.push_back(32'h00000204);
        run_job(16'd2, 9, 2, "j2");

        exp_q.push_back(32'h00000204);
        run_job(16'd0, 3, 0, "j0");

        // MAC command held off by cmd_ready while operands keep wiggling.
        mac_stall = 1'b1;
        exp_q.push_back(32'h00000618);
        m0 = nmac;
        @(negedge clk);
        start = 1'b1;
        len   = 16'd1;
        @(negedge clk);
        start    = 1'b0;
        op_valid = 1'b1;
        op_a     = 32'h02020202;
        op_b     = 32'h03030303;
        cyc      = 0;
        while (!(cmd_valid && cmd_payload_function_id == 10'h000) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            op_valid = i[0];
            op_a     = $urandom;
            op_b     = $urandom;
            chk("stall_cmd_valid", {31'd0, cmd_valid}, 32'd1);
            chk("stall_fid", {22'd0, cmd_payload_function_id}, 32'd0);
            chk("stall_in0", cmd_payload_inputs_0, 32'h02020202);
            chk("stall_in1", cmd_payload_inputs_1, 32'h03030303);
            chk("stall_op_ready", {31'd0, op_ready}, 32'd0);
            @(negedge clk);
        end
        mac_stall = 1'b0;
        op_valid  = 1'b0;
        cyc       = 0;
        while (done !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_done", {31'd0, done}, 32'd1);
        chk("stall_result", result, exp_q.pop_front());
        chk("stall_nmac", nmac - m0, 32'd1);
        @(negedge clk);

        // Reset while waiting for a MAC response.
        mute_mac = 1'b1;
        m0       = nmac;
        @(negedge clk);
        start = 1'b1;
        len   = 16'd4;
        @(negedge clk);
        start    = 1'b0;
        op_valid = 1'b1;
        op_a     = 32'h01010101;
        op_b     = 32'h01010101;
        cyc      = 0;
        while (!(rsp_ready && (nmac - m0) == 1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_in_mac_rsp", {31'd0, rsp_ready && (nmac - m0) == 1}, 32'd1);
        chk("rst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        chk("rst_async_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_async_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        chk("rst_async_result", result, 32'd0);
        op_valid = 1'b0;
        mute_mac = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pa.push_back(32'hFFFFFFFF); pb.push_back(32'h02020202);
        exp_q.push_back(32'h000003F8);
        run_job(16'd1, 6, 1, "after_rst");

`ifdef CFU_INIT_TIMEOUT_EN
        mute_all = 1'b1;
        exp_q.push_back(32'h000003F8);
        run_job(16'd1, 18, 0, "timeout");
        chk("timeout_err", {31'd0, err}, 32'd1);
        mute_all = 1'b0;
        @(negedge clk);
        start = 1'b1;
        len   = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("timeout_err_clr", {31'd0, err}, 32'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_next_done", {31'd0, done}, 32'd1);
`else
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
